banco_registros_pipe: RTL and testbench

Parametrised successor of the MIPS register bank for the pipelined datapath. Provides NUM_RD registered read ports and one write port on the rising edge. Adds a busy scoreboard so the hazard unit can detect reads of registers with an outstanding producer. Sits between decode (reads and issue) and writeback (write).

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 40 ++++
 rtl/banco_registros_pipe.sv | 66 ++++++
 tb/tb_banco_registros_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and defaults for the pipelined MIPS register bank
package regfile_pkg;
  localparam logic [31:0] PTR_RST_VAL = 32'h1000_0000;
  localparam int REG_ZERO = 0;
  localparam int REG_AT = 1;
  localparam int REG_V0 = 2;
  localparam int REG_A0 = 4;
  localparam int REG_T0 = 8;
  localparam int REG_T3 = 11;
  localparam int REG_T4 = 12;
  localparam int REG_S0 = 16;
  localparam int REG_GP = 28;
  localparam int REG_SP = 29;
  localparam int REG_FP = 30;
  localparam int REG_RA = 31;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_ZERO_REG = 1;
  function automatic logic is_ptr_reg(input int r);
    return r == REG_T3 || r == REG_T4;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with set-over-clear priority and per-port lookup (REGFILE_BYPASS_EN selects post-update lookup)
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid_i,
  input  logic [ADDR_W-1:0]        issue_reg_i,
  input  logic                     clr_valid_i,
  input  logic [ADDR_W-1:0]        clr_reg_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [2**ADDR_W-1:0]     busy_vec_o,
  output logic [NUM_RD-1:0]        port_busy_o
);
  logic [2**ADDR_W-1:0] busy_q, busy_d;
  // a newer producer beats a retiring one; the zero register never becomes busy
  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i) busy_d[clr_reg_i] = 1'b0;
    if (issue_valid_i) busy_d[issue_reg_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end
  // scoreboard state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy_q <= '0;
    else busy_q <= busy_d;
  // per-port busy lookup, pre-edge view unless bypass is built in
  always_comb begin
    port_busy_o = '0;
    for (int i = 0; i < NUM_RD; i++)
`ifdef REGFILE_BYPASS_EN
      port_busy_o[i] = busy_d[rd_addr_i[i*ADDR_W +: ADDR_W]];
`else
      port_busy_o[i] = busy_q[rd_addr_i[i*ADDR_W +: ADDR_W]];
`endif
  end
  assign busy_vec_o = busy_q;
endmodule

// File: rtl/banco_registros_pipe.sv
// banco_registros_pipe: register bank with NUM_RD registered read ports, one write port and a busy scoreboard (REGFILE_BYPASS_EN forwards same-edge writes)
module banco_registros_pipe import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     read_reg_flag,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     write_reg_flag,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_reg,
  output logic [2**ADDR_W-1:0]     busy_vec
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0] rd_busy_q, rd_busy_d;
  logic we;
  function automatic logic [DATA_W-1:0] rst_val(input int r);
    return is_ptr_reg(r) ? DATA_W'(PTR_RST_VAL) : '0;
  endfunction
  assign we = !write_reg_flag && !(ZERO_REG != 0 && write_reg == '0);
  regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .issue_valid_i(issue_valid),
    .issue_reg_i(issue_reg),
    .clr_valid_i(!write_reg_flag),
    .clr_reg_i(write_reg),
    .rd_addr_i(rd_addr),
    .busy_vec_o(busy_vec),
    .port_busy_o(rd_busy_d)
  );
  // storage: pointer registers come out of reset preloaded, a dropped zero-register write never lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int r = 0; r < DEPTH; r++) regs_q[r] <= rst_val(r);
    else if (we) regs_q[write_reg] <= write_data;
  // read mux per port; with bypass a same-edge write is forwarded
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_RD; i++)
`ifdef REGFILE_BYPASS_EN
      rd_data_d[i*DATA_W +: DATA_W] = (we && write_reg == rd_addr[i*ADDR_W +: ADDR_W]) ? write_data : regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
`else
      rd_data_d[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
`endif
  end
  // read port registers, held while the active-low read enable is high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else if (!read_reg_flag) begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;
endmodule

// File: tb/tb_banco_registros_pipe.sv
// tb_banco_registros_pipe: random and directed checks against an array-based model of the register bank
module tb_banco_registros_pipe;
  import regfile_pkg::*;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic read_reg_flag = 1'b1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_busy;
  logic write_reg_flag = 1'b1;
  logic [AW-1:0] write_reg = '0;
  logic [DW-1:0] write_data = '0;
  logic issue_valid = 1'b0;
  logic [AW-1:0] issue_reg = '0;
  logic [31:0] busy_vec;
  logic r2_flag = 1'b1;
  logic [11:0] r2_addr = '0;
  logic [63:0] r2_data;
  logic [3:0] r2_busy;
  logic w2_flag = 1'b1;
  logic [2:0] w2_reg = '0;
  logic [15:0] w2_data = '0;
  logic i2_valid = 1'b0;
  logic [2:0] i2_reg = '0;
  logic [7:0] busy2;
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] m_regs [32];
  logic [31:0] m_busy;
  logic [DW-1:0] e_d [NR];
  logic [NR-1:0] e_b;
  logic [15:0] v2 [4];

  banco_registros_pipe dut (
    .clk(clk), .rst_n(rst_n), .read_reg_flag(read_reg_flag), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .write_reg_flag(write_reg_flag),
    .write_reg(write_reg), .write_data(write_data), .issue_valid(issue_valid),
    .issue_reg(issue_reg), .busy_vec(busy_vec)
  );

  banco_registros_pipe #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .read_reg_flag(r2_flag), .rd_addr(r2_addr),
    .rd_data(r2_data), .rd_busy(r2_busy), .write_reg_flag(w2_flag),
    .write_reg(w2_reg), .write_data(w2_data), .issue_valid(i2_valid),
    .issue_reg(i2_reg), .busy_vec(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = (r == 11 || r == 12) ? 32'h1000_0000 : '0;
    m_busy = '0;
    e_b = '0;
    for (int i = 0; i < NR; i++) e_d[i] = '0;
  endfunction

  task automatic compare_all();
    for (int i = 0; i < NR; i++) chk($sformatf("rd_data%0d", i), rd_data[i*DW +: DW], e_d[i]);
    chk("rd_busy", rd_busy, e_b);
    chk("busy_vec", busy_vec, m_busy);
  endtask

  task automatic cyc();
    logic [DW-1:0] old_r [32];
    logic [31:0] old_b, new_b;
    int a;
    @(posedge clk);
    old_r = m_regs;
    old_b = m_busy;
    new_b = m_busy;
    if (!write_reg_flag) new_b[write_reg] = 1'b0;
    if (issue_valid) new_b[issue_reg] = 1'b1;
    new_b[0] = 1'b0;
    if (!write_reg_flag && write_reg != 0) m_regs[write_reg] = write_data;
    if (!read_reg_flag)
      for (int i = 0; i < NR; i++) begin
        a = int'(rd_addr[i*AW +: AW]);
        e_d[i] = BYP ? m_regs[a] : old_r[a];
        e_b[i] = BYP ? new_b[a] : old_b[a];
      end
    m_busy = new_b;
    #1;
    compare_all();
  endtask

  function automatic logic [AW-1:0] raddr();
    return $urandom_range(0, 1) == 0 ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
  endfunction

  initial begin
    v2[0] = 16'h0055; v2[1] = 16'hA1A1; v2[2] = 16'hB2B2; v2[3] = 16'hC3C3;
    m_reset();
    #12 rst_n = 1'b1;
    read_reg_flag = 1'b0;
    rd_addr = {5'd12, 5'd11};
    cyc();
    chk("rst_r11", rd_data[31:0], 32'h1000_0000);
    chk("rst_r12", rd_data[63:32], 32'h1000_0000);
    rd_addr = {5'd8, 5'd8};
    cyc();
    chk("rst_r8", rd_data[31:0], 32'h0);
    write_reg_flag = 1'b0; write_reg = 5'd9; write_data = 32'hDEAD_BEEF;
    rd_addr = {5'd0, 5'd9};
    cyc();
    write_reg = 5'd0; write_data = 32'h1234;
    cyc();
    chk("wr_r9", rd_data[31:0], 32'hDEAD_BEEF);
    write_reg_flag = 1'b1;
    rd_addr = {5'd9, 5'd0};
    cyc();
    chk("wr_r0_dropped", rd_data[31:0], 32'h0);
    chk("wr_r9_port1", rd_data[63:32], 32'hDEAD_BEEF);
    write_reg_flag = 1'b0; write_reg = 5'd5; write_data = 32'h1;
    cyc();
    write_data = 32'h2;
    rd_addr = {5'd5, 5'd5};
    cyc();
    chk("rdw_r5", rd_data[31:0], BYP ? 32'h2 : 32'h1);
    write_reg_flag = 1'b1;
    cyc();
    chk("rdw_r5_after", rd_data[31:0], 32'h2);
    issue_valid = 1'b1; issue_reg = 5'd7;
    rd_addr = {5'd7, 5'd7};
    cyc();
    chk("sb_issue", busy_vec[7], 1'b1);
    issue_valid = 1'b0;
    cyc();
    chk("sb_rd_busy", rd_busy[0], 1'b1);
    write_reg_flag = 1'b0; write_reg = 5'd7; write_data = 32'h77;
    cyc();
    chk("sb_clear", busy_vec[7], 1'b0);
    issue_valid = 1'b1; issue_reg = 5'd7;
    cyc();
    chk("sb_set_wins", busy_vec[7], 1'b1);
    issue_reg = 5'd0; write_reg_flag = 1'b1;
    cyc();
    chk("sb_zero", busy_vec[0], 1'b0);
    chk("sb_r7_kept", busy_vec[7], 1'b1);
    issue_valid = 1'b0;
    rd_addr = {5'd9, 5'd9};
    cyc();
    read_reg_flag = 1'b1;
    rd_addr = {5'd11, 5'd3};
    cyc();
    cyc();
    chk("hold", rd_data[31:0], 32'hDEAD_BEEF);
    write_reg_flag = 1'b0; write_reg = 5'd3; write_data = 32'hABC;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_rd_data", rd_data, 64'h0);
    chk("arst_rd_busy", rd_busy, 2'b00);
    chk("arst_busy_vec", busy_vec, 32'h0);
    write_reg_flag = 1'b1;
    #2 rst_n = 1'b1;
    read_reg_flag = 1'b0;
    rd_addr = {5'd11, 5'd3};
    cyc();
    chk("arst_lost_wr", rd_data[31:0], 32'h0);
    chk("arst_r11", rd_data[63:32], 32'h1000_0000);
    for (int n = 0; n < 500; n++) begin
      read_reg_flag = $urandom_range(0, 3) == 0;
      rd_addr = {raddr(), raddr()};
      write_reg_flag = $urandom_range(0, 1) == 0;
      write_reg = raddr();
      write_data = $urandom;
      issue_valid = $urandom_range(0, 2) == 0;
      issue_reg = raddr();
      cyc();
    end
    read_reg_flag = 1'b1; write_reg_flag = 1'b1; issue_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w2_flag = 1'b0; w2_reg = 3'(k); w2_data = v2[k];
      @(posedge clk); #1;
    end
    w2_flag = 1'b1;
    r2_flag = 1'b0;
    r2_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    i2_valid = 1'b1; i2_reg = 3'd0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) chk($sformatf("p2_port%0d", k), r2_data[k*16 +: 16], v2[k]);
    chk("p2_busy0", busy2, 8'h01);
    i2_valid = 1'b0;
    r2_addr = {3'd0, 3'd4, 3'd0, 3'd2};
    @(posedge clk); #1;
    chk("p2_mix", r2_data, {16'h0055, 16'h0000, 16'h0055, 16'hB2B2});
    chk("p2_rd_busy", r2_busy, 4'b1010);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
